// File: rtl/frame_stage_sequencer.sv
// frame_stage_sequencer
//   Top-level scheduler for the image compressor. Runs the enabled processing
//   stages in index order. Each stage gets a one-cycle enable pulse, and the
//   sequencer then waits for that stage's finished bit. While a stage runs,
//   the shared SRAM port and the four shared 32x32 multipliers are routed to
//   it. A per-stage watchdog aborts the frame if a stage never finishes.
//
// Parameters
//   STAGE_MASK     bit k set -> stage k is part of the frame
//   GAP_CYCLES     idle cycles between two stages, bus at defaults (0..15)
//   TIMEOUT_CYCLES max RUN cycles per stage before the frame is aborted
//
// Ports
//   Clock, Resetn            clock (posedge), async active-low reset
//   start                    frame request, only looked at while idle
//   stage_finished[2:0]      per-stage completion, only the active bit in RUN
//   stageK_SRAM_*            SRAM request from stage K (K = 0..2)
//   stageK_MUL_OP_A/B        multiplier operands from stage K, [32m+31:32m] = MULm+1
//   stage_enable[2:0]        one-hot launch pulse
//   SRAM_*, MUL_OP_A/B       shared resources, driven by the running stage
//   active_stage[1:0]        stage being launched / run / waited for
//   busy, done, error        status: not idle, end-of-frame pulse, sticky abort

module frame_stage_sequencer #(
    parameter logic [2:0]  STAGE_MASK     = 3'b111,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         start,
    input  logic [2:0]   stage_finished,

    input  logic [19:0]  stage0_SRAM_address,
    input  logic [15:0]  stage0_SRAM_write_data,
    input  logic         stage0_SRAM_we_n,
    input  logic [127:0] stage0_MUL_OP_A,
    input  logic [127:0] stage0_MUL_OP_B,

    input  logic [19:0]  stage1_SRAM_address,
    input  logic [15:0]  stage1_SRAM_write_data,
    input  logic         stage1_SRAM_we_n,
    input  logic [127:0] stage1_MUL_OP_A,
    input  logic [127:0] stage1_MUL_OP_B,

    input  logic [19:0]  stage2_SRAM_address,
    input  logic [15:0]  stage2_SRAM_write_data,
    input  logic         stage2_SRAM_we_n,
    input  logic [127:0] stage2_MUL_OP_A,
    input  logic [127:0] stage2_MUL_OP_B,

    output logic [2:0]   stage_enable,
    output logic [19:0]  SRAM_address,
    output logic [15:0]  SRAM_write_data,
    output logic         SRAM_we_n,
    output logic [127:0] MUL_OP_A,
    output logic [127:0] MUL_OP_B,
    output logic [1:0]   active_stage,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        S_SEQ_IDLE,
        S_SEQ_LAUNCH,
        S_SEQ_RUN,
        S_SEQ_GAP,
        S_SEQ_DONE
    } seq_state_e;

    // The gap counter counts down to zero, so it is loaded with GAP_CYCLES-1.
    localparam logic [3:0]  GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic [23:0] WD_LAST  = TIMEOUT_CYCLES - 24'd1;

    seq_state_e  state_q, state_d;
    logic [1:0]  active_stage_q, active_stage_d;
    logic [23:0] wd_cnt_q, wd_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]  stage_enable_q, stage_enable_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    // Lowest stage in the mask, and the lowest one above the active stage.
    // Scanning downward lets the lowest match overwrite the others.
    logic [1:0] first_stage;
    logic [1:0] next_stage;
    logic       has_next;

    always_comb begin
        first_stage = 2'd0;
        next_stage  = active_stage_q;
        has_next    = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (STAGE_MASK[k]) begin
                first_stage = 2'(k);
                if (k > int'(active_stage_q)) begin
                    next_stage = 2'(k);
                    has_next   = 1'b1;
                end
            end
        end
    end

    // Only the active stage's finished bit is ever looked at.
    logic fin_active;

    always_comb begin
        case (active_stage_q)
            2'd0:    fin_active = stage_finished[0];
            2'd1:    fin_active = stage_finished[1];
            2'd2:    fin_active = stage_finished[2];
            default: fin_active = 1'b0;
        endcase
    end

    // Next-state logic. Status outputs are derived from the next state, so
    // they are registered and line up with the state they describe.
    always_comb begin
        state_d        = state_q;
        active_stage_d = active_stage_q;
        wd_cnt_d       = wd_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        error_d        = error_q;

        case (state_q)
            S_SEQ_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (STAGE_MASK != 3'b000) begin
                        active_stage_d = first_stage;
                        state_d        = S_SEQ_LAUNCH;
                    end else begin
                        state_d = S_SEQ_DONE;
                    end
                end
            end
            S_SEQ_LAUNCH: begin
                wd_cnt_d = 24'd0;
                state_d  = S_SEQ_RUN;
            end
            S_SEQ_RUN: begin
                wd_cnt_d = wd_cnt_q + 24'd1;
                // Finished is tested first so it beats a same-cycle timeout.
                if (fin_active) begin
                    if (has_next) begin
                        active_stage_d = next_stage;
                        if (GAP_CYCLES == 0) begin
                            state_d = S_SEQ_LAUNCH;
                        end else begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = S_SEQ_GAP;
                        end
                    end else begin
                        state_d = S_SEQ_DONE;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = S_SEQ_DONE;
                end
            end
            S_SEQ_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_SEQ_LAUNCH;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            S_SEQ_DONE: begin
                state_d = S_SEQ_IDLE;
            end
            default: begin
                state_d = S_SEQ_IDLE;
            end
        endcase

        stage_enable_d = (state_d == S_SEQ_LAUNCH) ? (3'b001 << active_stage_d) : 3'b000;
        busy_d         = (state_d != S_SEQ_IDLE);
        done_d         = (state_d == S_SEQ_DONE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q        <= S_SEQ_IDLE;
            active_stage_q <= 2'd0;
            wd_cnt_q       <= 24'd0;
            gap_cnt_q      <= 4'd0;
            stage_enable_q <= 3'b000;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_stage_q <= active_stage_d;
            wd_cnt_q       <= wd_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            stage_enable_q <= stage_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign stage_enable = stage_enable_q;
    assign active_stage = active_stage_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

    // Shared-resource mux. Purely combinational off registered state, so a
    // running stage sees its requests reach SRAM/MUL in the same cycle. Any
    // state other than RUN parks the bus, which keeps we_n high across GAP
    // and LAUNCH and blocks writes from stages that are not running.
    always_comb begin
        SRAM_address    = 20'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        MUL_OP_A        = 128'd0;
        MUL_OP_B        = 128'd0;
        if (state_q == S_SEQ_RUN) begin
            case (active_stage_q)
                2'd0: begin
                    SRAM_address    = stage0_SRAM_address;
                    SRAM_write_data = stage0_SRAM_write_data;
                    SRAM_we_n       = stage0_SRAM_we_n;
                    MUL_OP_A        = stage0_MUL_OP_A;
                    MUL_OP_B        = stage0_MUL_OP_B;
                end
                2'd1: begin
                    SRAM_address    = stage1_SRAM_address;
                    SRAM_write_data = stage1_SRAM_write_data;
                    SRAM_we_n       = stage1_SRAM_we_n;
                    MUL_OP_A        = stage1_MUL_OP_A;
                    MUL_OP_B        = stage1_MUL_OP_B;
                end
                2'd2: begin
                    SRAM_address    = stage2_SRAM_address;
                    SRAM_write_data = stage2_SRAM_write_data;
                    SRAM_we_n       = stage2_SRAM_we_n;
                    MUL_OP_A        = stage2_MUL_OP_A;
                    MUL_OP_B        = stage2_MUL_OP_B;
                end
                default: begin
                    SRAM_we_n = 1'b1;
                end
            endcase
        end
    end

endmodule
